alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the 32-bit ALU.
- Accepts decoded ops with register-file read data and an optional 16-bit immediate.
- Resolves RAW hazards by forwarding from the op leaving the stage this cycle and from the most recently retired op.
- Registers A, B and SEL for the ALU behind a valid/ready handshake, with stall and flush.
- The ALU's R output feeds back into this block as the forwarding source.

Parameters:
DW, 32, datapath width (A, B, R)
RW, 5, register address width; address 0 is the hard-zero register

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  kill the op held in the stage
in_valid  in  1  decoded op present
in_ready  out  1  stage can accept the op this cycle
in_sel  in  3  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 slt, 5 mul, 6 div, 7 pass B)
in_rs  in  RW  source register for A
in_rt  in  RW  source register for B (ignored when in_use_imm)
in_rd  in  RW  destination register
in_wen  in  1  op writes in_rd
in_rs_data  in  DW  register-file value of in_rs
in_rt_data  in  DW  register-file value of in_rt
in_imm  in  16  immediate
in_use_imm  in  1  B comes from the immediate
in_zext  in  1  zero-extend the immediate (else sign-extend)
alu_r  in  DW  ALU result for the currently held op (combinational from out_a/out_b/out_sel)
out_valid  out  1  held op valid
out_ready  in  1  downstream accepts the held op (with alu_r)
out_a  out  DW  ALU operand A
out_b  out  DW  ALU operand B
out_sel  out  3  ALU opcode
out_rd  out  RW  destination of held op
out_wen  out  1  write enable of held op
out_dz  out  1  held op is a divide with B == 0

Behaviour:
- Reset: all outputs and internal state go to 0, including out_valid, out_a, out_b, out_sel, out_rd, out_wen, out_dz, last_valid, last_rd and last_r. in_ready is 1 after reset.
- Handshake definitions:
  - fire = out_valid & out_ready & ~flush
  - accept = in_valid & in_ready
  - in_ready = ~flush & (~out_valid | out_ready), combinational
- Latency: one cycle from accept to out_valid. Back-to-back accepts sustain 1 op/cycle.
- Next-state priority: rst > flush > accept.
  - flush: out_valid <= 0; no accept that cycle.
  - accept: capture the op, out_valid <= 1.
  - Otherwise, if fire, out_valid <= 0.
  - Otherwise hold all outputs stable.
- Stall: while out_valid & ~out_ready, out_* are unchanged and in_ready = 0.
- Retire register: on fire with out_wen & out_rd != 0, set last_valid <= 1, last_rd <= out_rd, last_r <= alu_r. Otherwise unchanged. Flush does not modify it.
- Forwarding, applied independently to rs (for A) and rt (for B, only when ~in_use_imm):
  1. Register address 0 always gives 0. It is never forwarded, and the file value is ignored.
  2. If fire & out_wen & out_rd == addr, use alu_r (op leaving this cycle).
  3. Else if last_valid & last_rd == addr, use last_r.
  4. Else use in_*_data.
- Immediate B: when in_use_imm, B = {16'b0, in_imm} if in_zext, else {{16{in_imm[15]}}, in_imm}. Bits above 32 are zero when DW > 32.
- out_dz <= (in_sel == 6) & (resolved B == 0), captured on accept and cleared with out_valid. The stage does not block the op; downstream decides.
- Reset mid-stall or mid-forward: all state clears in one cycle, and the pending in-stage op is lost.
- Flush with out_ready high in the same cycle: no retire, and the retire register is unchanged.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_a=out_b=0, out_dz=0; after release in_ready=1.
- Basic add: in_sel=0, rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_sel=0; one op per cycle over 8 consecutive ops.
- Immediates: in_imm=16'hFFFE, in_zext=0 -> out_b=32'hFFFFFFFE; in_zext=1 -> out_b=32'h0000FFFE.
- Forwarding: op1 add r3=5+7 (fires) then op2 reads r3 with stale rs_data=0 -> out_a=12; op3 reads r3 one op later -> out_a=12 via last_r; op reading r0 with prior write to r0 -> operand 0.
- Stall/flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush while holding op -> out_valid=0 next cycle, last_r unchanged, op never retires.
- Divide by zero: in_sel=6, rt_data=0 -> out_dz=1; same with rt forwarded as 4 -> out_dz=0.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Decoder -> operand stage -> ALU bus: decoded op in, registered ALU operands out, ALU result back.
interface alu_operand_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_sel;
   logic [RW-1:0] in_rs;
   logic [RW-1:0] in_rt;
   logic [RW-1:0] in_rd;
   logic          in_wen;
   logic [DW-1:0] in_rs_data;
   logic [DW-1:0] in_rt_data;
   logic [15:0]   in_imm;
   logic          in_use_imm;
   logic          in_zext;
   logic [DW-1:0] alu_r;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic [2:0]    out_sel;
   logic [RW-1:0] out_rd;
   logic          out_wen;
   logic          out_dz;

   modport master (
      output flush, in_valid, in_sel, in_rs, in_rt, in_rd, in_wen,
             in_rs_data, in_rt_data, in_imm, in_use_imm, in_zext, alu_r, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_wen, out_dz
   );

   modport slave (
      input  flush, in_valid, in_sel, in_rs, in_rt, in_rd, in_wen,
             in_rs_data, in_rt_data, in_imm, in_use_imm, in_zext, alu_r, out_ready,
      output in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_wen, out_dz
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves RAW hazards by forwarding, then registers A/B/SEL for the ALU
// behind a valid/ready handshake with stall and flush.
module alu_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic                clk,
   input  logic                rst,
   alu_operand_stage_if.slave  bus
);
   localparam logic [2:0] SEL_DIV = 3'd6;

   logic          vld_p1;
   logic          wen_p1;
   logic          dz_p1;
   logic [2:0]    sel_p1;
   logic [RW-1:0] rd_p1;
   logic [DW-1:0] a_p1;
   logic [DW-1:0] b_p1;

   logic          last_valid;
   logic [RW-1:0] last_rd;
   logic [DW-1:0] last_r;

   logic          fire;
   logic          ready;
   logic          accept;
   logic [DW-1:0] a_p0;
   logic [DW-1:0] b_p0;
   logic          dz_p0;

   // Immediate is widened to 32 bits first; anything above bit 31 stays zero.
   function automatic logic [DW-1:0] imm_ext(input logic [15:0] imm, input logic zext);
      logic signed [15:0] simm;
      logic        [31:0] ext;
      simm = imm;
      ext  = zext ? {16'b0, imm} : 32'(simm);
      return DW'(ext);
   endfunction

   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] addr,
      input logic [DW-1:0] file_data,
      input logic          live_v,
      input logic [RW-1:0] live_rd,
      input logic [DW-1:0] live_r,
      input logic          hist_v,
      input logic [RW-1:0] hist_rd,
      input logic [DW-1:0] hist_r
   );
      if (addr == '0)                   return '0;
      if (live_v && (live_rd == addr))  return live_r;
      if (hist_v && (hist_rd == addr))  return hist_r;
      return file_data;
   endfunction

   assign fire   = vld_p1 & bus.out_ready & ~bus.flush;
   assign ready  = ~bus.flush & (~vld_p1 | bus.out_ready);
   assign accept = bus.in_valid & ready;

   // Stage p0: operand resolution for the incoming op
   always_comb begin
      a_p0 = fwd(bus.in_rs, bus.in_rs_data, fire & wen_p1, rd_p1, bus.alu_r,
                 last_valid, last_rd, last_r);
      if (bus.in_use_imm)
         b_p0 = imm_ext(bus.in_imm, bus.in_zext);
      else
         b_p0 = fwd(bus.in_rt, bus.in_rt_data, fire & wen_p1, rd_p1, bus.alu_r,
                    last_valid, last_rd, last_r);
      dz_p0 = (bus.in_sel == SEL_DIV) && (b_p0 == '0);
   end

   // Stage p1: registered operands presented to the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         wen_p1     <= 1'b0;
         dz_p1      <= 1'b0;
         sel_p1     <= '0;
         rd_p1      <= '0;
         a_p1       <= '0;
         b_p1       <= '0;
         last_valid <= 1'b0;
         last_rd    <= '0;
         last_r     <= '0;
      end else begin
         if (bus.flush) begin
            vld_p1 <= 1'b0;
            dz_p1  <= 1'b0;
         end else if (accept) begin
            vld_p1 <= 1'b1;
            wen_p1 <= bus.in_wen;
            dz_p1  <= dz_p0;
            sel_p1 <= bus.in_sel;
            rd_p1  <= bus.in_rd;
            a_p1   <= a_p0;
            b_p1   <= b_p0;
         end else if (fire) begin
            vld_p1 <= 1'b0;
            dz_p1  <= 1'b0;
         end
         // Writes to the hard-zero register are never remembered for forwarding.
         if (fire && wen_p1 && (rd_p1 != '0)) begin
            last_valid <= 1'b1;
            last_rd    <= rd_p1;
            last_r     <= bus.alu_r;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = vld_p1;
   assign bus.out_a     = a_p1;
   assign bus.out_b     = b_p1;
   assign bus.out_sel   = sel_p1;
   assign bus.out_rd    = rd_p1;
   assign bus.out_wen   = wen_p1;
   assign bus.out_dz    = dz_p1;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed hazard/stall/flush steps then random traffic, checked
// against an architectural register model with a lagging register file.
module tb_alu_operand_stage;
   localparam int DW = 32;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_operand_stage_if #(.DW(DW), .RW(RW)) bus ();
   alu_operand_stage #(.DW(DW), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [31:0] alu(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd5:    return a * b;
         3'd6:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return b;
      endcase
   endfunction

   always_comb bus.alu_r = alu(bus.out_sel, bus.out_a, bus.out_b);

   // arch: true register values once every retired op is applied; rf: what the register
   // file returns, which only sees a retired write two cycles after it retires.
   logic [31:0] arch [32];
   logic [31:0] rf   [32];
   logic        m_vld, m_wen, m_dz;
   logic [2:0]  m_sel;
   logic [4:0]  m_rd;
   logic [31:0] m_a, m_b;
   logic        wb_v;
   logic [4:0]  wb_rd;
   logic [31:0] wb_val;
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic wen, input logic [15:0] imm, input logic use_imm,
                        input logic zext, input logic ordy, input logic fl);
      bus.in_valid   = v;
      bus.in_sel     = sel;
      bus.in_rs      = rs;
      bus.in_rt      = rt;
      bus.in_rd      = rd;
      bus.in_wen     = wen;
      bus.in_imm     = imm;
      bus.in_use_imm = use_imm;
      bus.in_zext    = zext;
      bus.out_ready  = ordy;
      bus.flush      = fl;
      bus.in_rs_data = (rs == 5'd0) ? $urandom : rf[rs];
      bus.in_rt_data = (rt == 5'd0) ? $urandom : rf[rt];
   endtask

   function automatic logic [31:0] arch_val(input logic [4:0] addr, input logic wr, input logic [31:0] r);
      if (addr == 5'd0)           return 32'd0;
      if (wr && addr == m_rd)     return r;
      return arch[addr];
   endfunction

   task automatic step();
      logic        rdy, fire, acc, wr;
      logic [31:0] r, ea, eb, ext;
      #1;
      rdy  = !bus.flush && (!m_vld || bus.out_ready);
      fire = m_vld && bus.out_ready && !bus.flush && !rst;
      acc  = bus.in_valid && rdy && !rst;
      if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      r   = alu(m_sel, m_a, m_b);
      wr  = fire && m_wen && (m_rd != 5'd0);
      ext = bus.in_zext ? {16'h0, bus.in_imm} : {{16{bus.in_imm[15]}}, bus.in_imm};
      ea  = arch_val(bus.in_rs, wr, r);
      eb  = bus.in_use_imm ? ext : arch_val(bus.in_rt, wr, r);
      @(posedge clk);
      if (wb_v) rf[wb_rd] = wb_val;
      wb_v = wr; wb_rd = m_rd; wb_val = r;
      if (wr) arch[m_rd] = r;
      if (rst) begin
         m_vld = 0; m_wen = 0; m_dz = 0; m_sel = 0; m_rd = 0; m_a = 0; m_b = 0;
      end else if (bus.flush) begin
         m_vld = 0; m_dz = 0;
      end else if (acc) begin
         m_vld = 1; m_wen = bus.in_wen; m_sel = bus.in_sel; m_rd = bus.in_rd;
         m_a = ea; m_b = eb; m_dz = (bus.in_sel == 3'd6) && (eb == 32'd0);
      end else if (fire) begin
         m_vld = 0; m_dz = 0;
      end
      #2;
      chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
      chk("out_a",     bus.out_a, m_a);
      chk("out_b",     bus.out_b, m_b);
      chk("out_sel",   32'(bus.out_sel), 32'(m_sel));
      chk("out_rd",    32'(bus.out_rd), 32'(m_rd));
      chk("out_wen",   32'(bus.out_wen), 32'(m_wen));
      chk("out_dz",    32'(bus.out_dz), 32'(m_dz));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         arch[i] = (i == 0) ? 32'd0 : $urandom;
         rf[i]   = arch[i];
      end
      arch[1] = 32'd5;  rf[1] = 32'd5;
      arch[2] = 32'd7;  rf[2] = 32'd7;
      arch[5] = 32'd99; rf[5] = 32'd99;
      arch[6] = 32'd0;  rf[6] = 32'd0;
      m_vld = 0; m_wen = 0; m_dz = 0; m_sel = 0; m_rd = 0; m_a = 0; m_b = 0;
      wb_v = 0; wb_rd = 0; wb_val = 0;

      // Reset held two cycles with an op offered
      rst = 1'b1;
      drive(1, 3'd0, 5'd1, 5'd2, 5'd8, 1, 16'h0, 0, 0, 1, 0);
      step();
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_a", bus.out_a, 32'd0);
      chk("rst_b", bus.out_b, 32'd0);
      chk("rst_dz", 32'(bus.out_dz), 32'd0);
      rst = 1'b0;
      drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 0, 1, 0);
      #1 chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);
      step();

      // Eight back-to-back adds
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'd0, 5'd1, 5'd2, 5'(8 + i), 1, 16'h0, 0, 0, 1, 0);
         step();
         chk("add_valid", 32'(bus.out_valid), 32'd1);
         chk("add_a", bus.out_a, 32'd5);
         chk("add_b", bus.out_b, 32'd7);
         chk("add_sel", 32'(bus.out_sel), 32'd0);
      end

      // Immediate extension
      drive(1, 3'd0, 5'd1, 5'd0, 5'd20, 1, 16'hFFFE, 1, 0, 1, 0);
      step();
      chk("imm_sext", bus.out_b, 32'hFFFF_FFFE);
      drive(1, 3'd0, 5'd1, 5'd0, 5'd20, 1, 16'hFFFE, 1, 1, 1, 0);
      step();
      chk("imm_zext", bus.out_b, 32'h0000_FFFE);
      drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 0, 1, 0);
      step();

      // Forwarding: live result, retired result, hard-zero register
      drive(1, 3'd0, 5'd1, 5'd2, 5'd3, 1, 16'h0, 0, 0, 1, 0);
      step();
      drive(1, 3'd0, 5'd3, 5'd2, 5'd4, 0, 16'h0, 0, 0, 1, 0);
      bus.in_rs_data = 32'd0;
      step();
      chk("fwd_live_a", bus.out_a, 32'd12);
      drive(1, 3'd0, 5'd3, 5'd1, 5'd4, 0, 16'h0, 0, 0, 1, 0);
      bus.in_rs_data = 32'd0;
      step();
      chk("fwd_last_a", bus.out_a, 32'd12);
      drive(1, 3'd7, 5'd0, 5'd0, 5'd0, 1, 16'h1234, 1, 0, 1, 0);
      step();
      drive(1, 3'd0, 5'd0, 5'd0, 5'd9, 1, 16'h0, 0, 0, 1, 0);
      bus.in_rs_data = 32'hDEAD_BEEF;
      bus.in_rt_data = 32'h1234_5678;
      step();
      chk("r0_a", bus.out_a, 32'd0);
      chk("r0_b", bus.out_b, 32'd0);

      // Stall for three cycles with a new op waiting
      drive(1, 3'd2, 5'd1, 5'd2, 5'd10, 1, 16'h0, 0, 0, 1, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'd3, 5'd2, 5'd1, 5'd11, 1, 16'h0, 0, 0, 0, 0);
         #1 chk("stall_rdy", 32'(bus.in_ready), 32'd0);
         step();
         chk("stall_a", bus.out_a, 32'd5);
         chk("stall_sel", 32'(bus.out_sel), 32'd2);
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
      end
      drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 0, 1, 0);
      step();

      // Flush a held op that would write r5; it must never retire
      drive(1, 3'd0, 5'd1, 5'd2, 5'd5, 1, 16'h0, 0, 0, 1, 0);
      step();
      drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 0, 0, 0);
      step();
      drive(1, 3'd1, 5'd1, 5'd2, 5'd9, 1, 16'h0, 0, 0, 1, 1);
      step();
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      drive(1, 3'd0, 5'd5, 5'd5, 5'd9, 1, 16'h0, 0, 0, 1, 0);
      step();
      chk("flush_keep_a", bus.out_a, 32'd99);

      // Divide-by-zero flag
      drive(1, 3'd6, 5'd1, 5'd6, 5'd9, 1, 16'h0, 0, 0, 1, 0);
      step();
      chk("dz_set", 32'(bus.out_dz), 32'd1);
      drive(1, 3'd7, 5'd0, 5'd0, 5'd7, 1, 16'd4, 1, 0, 1, 0);
      step();
      drive(1, 3'd6, 5'd1, 5'd7, 5'd9, 1, 16'h0, 0, 0, 1, 0);
      bus.in_rt_data = 32'd0;
      step();
      chk("dz_fwd", 32'(bus.out_dz), 32'd0);
      chk("dz_fwd_b", bus.out_b, 32'd4);
      drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 0, 1, 0);
      step();

      // Random traffic over a small register window to provoke hazards
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) != 0, 3'($urandom), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 3) == 0,
               1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
